apb_ram_completer: RTL
======================

Name: apb_ram_completer

Overview:
Parametrised APB3 completer fronting an on-chip word-addressed RAM. It is the next generation of the team's APB RAM slave.
- Adds configurable depth and data width independent of address width.
- Adds programmable wait states, a write-protected upper region, and error responses for misaligned, out-of-range and protected accesses.
- Sits on the peripheral APB segment behind the bridge; one instance per memory-mapped scratch/config RAM.

Parameters:
ADDR_WIDTH, 32, width of PADDR (byte address)
DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 8, 16, 32 or 64
DEPTH, 64, number of DATA_WIDTH words; power of two, >= 2
WAIT_STATES, 0, access-phase cycles with PREADY low before completion; 0..15
RO_BASE, DEPTH, first word index of the write-protected region; RO_BASE = DEPTH means no protected region

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  synchronous active-low reset
PADDR  in  ADDR_WIDTH  byte address
PSEL  in  1  completer select
PENABLE  in  1  access phase indicator
PWRITE  in  1  1 = write, 0 = read
PWDATA  in  DATA_WIDTH  write data
PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0
PREADY  out  1  transfer completion
PSLVERR  out  1  error response, valid only when PREADY=1

Behaviour:
- Reset (PRESETn=0 at a rising edge):
  - PREADY=0, PSLVERR=0, PRDATA=0, FSM to IDLE.
  - All DEPTH words cleared to 0 at that edge.
  - Reset mid-transfer aborts it with no memory write.
- Address decode:
  - BYTES=DATA_WIDTH/8; idx = PADDR >> log2(BYTES).
  - Error (err) if any of: PADDR[log2(BYTES)-1:0] != 0 (misaligned); idx >= DEPTH (full upper address bits checked, no aliasing); PWRITE=1 and idx >= RO_BASE.
  - Reads from the RO region are legal.
- FSM states, all outputs registered:
  - IDLE: PREADY=0.
    - On PSEL=1 and PENABLE=0 (setup), load wait counter cnt<=WAIT_STATES.
    - If WAIT_STATES=0, go to RESP and load the response at this edge. Otherwise go to WAIT.
    - PSEL=1 with PENABLE=1 in IDLE is a protocol error: ignore it and stay in IDLE.
  - WAIT: PREADY=0.
    - cnt decrements each cycle.
    - When cnt=1, load the response and go to RESP.
    - If PSEL=0, abort and go to IDLE with no write.
  - RESP: PREADY=1 for exactly one cycle (the completing access cycle).
    - At the edge ending this cycle, if PSEL=1 and PENABLE=1 and PWRITE=1 and !err, write mem[idx]<=PWDATA.
    - Then PREADY<=0, PSLVERR<=0, go to IDLE.
    - If PSEL=0 in RESP, no write; go to IDLE.
- Response load:
  - PSLVERR<=err.
  - PRDATA<=mem[idx] for a legal read, otherwise 0. PRDATA is 0 for writes and errors.
  - PRDATA holds its value after completion until the next response load.
- Latency: the transfer takes 2+WAIT_STATES cycles (setup, WAIT_STATES low-PREADY access cycles, one PREADY=1 cycle).
- Back-to-back: a setup phase in the cycle after RESP is accepted from IDLE with no idle gap required.
- Write visibility: a read immediately following a write to the same index returns the new data, since the write commits before the next setup edge.
- Errored write: memory unchanged, PREADY still asserted so the requester never stalls.
- Address/data are sampled at response-load time. APB guarantees they are stable across setup/access; no extra capture register.

Decomposition:
- Package apb_ram_pkg:
  - state_t enum {IDLE, WAIT, RESP} (2 bits).
  - Function clog2-based helper for the byte-offset width.
  - Localparam ranges for WAIT_STATES legality.
- Sub-module apb_ram_array (DATA_WIDTH, DEPTH):
  - Synchronous write port (we, waddr, wdata).
  - Combinational read port (raddr -> rdata).
  - Synchronous active-low clear on PRESETn.
- The top holds the FSM, wait counter and decode.

Test Plan:
- Reset, then read idx 5 (PADDR=0x14, WAIT_STATES=0) -> PREADY high in first access cycle, PRDATA=0, PSLVERR=0.
- Write 0xDEADBEEF to PADDR=0x08, then back-to-back read of 0x08 -> read returns 0xDEADBEEF, PSLVERR=0; each transfer 2 cycles.
- WAIT_STATES=3: write then read PADDR=0x10 -> PREADY low for 3 access cycles, high on the 4th; total 5 cycles; data 0x12345678 returned.
- Error cases, each must complete with PREADY=1, PSLVERR=1, PRDATA=0, memory unchanged:
  - Misaligned PADDR=0x06.
  - PADDR=0x100 with DEPTH=64.
  - Write to idx 60 with RO_BASE=60; a subsequent read of idx 60 returns 0, PSLVERR=0.
- Assert PRESETn=0 during WAIT of a write with WAIT_STATES=2 -> no write occurs, PREADY=0, all words read back 0 after reset.
- Drop PSEL during WAIT (protocol abort) -> FSM returns to IDLE, no write; next legal transfer completes normally.

Source files
------------

// File: rtl/apb_ram_pkg.sv
// Shared types and constants for the APB RAM completer and its storage array.
package apb_ram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WAIT_STATES_MIN = 0;
   localparam int WAIT_STATES_MAX = 15;
   localparam int CNT_WIDTH       = $clog2(WAIT_STATES_MAX + 1);

   // Number of low PADDR bits that select a byte inside one data word.
   function automatic int byte_offset_width(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/apb_ram_array.sv
// Word-addressed storage: one synchronous write port, one combinational read
// port, and a synchronous clear of every word while PRESETn is low.
module apb_ram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   localparam int IDXW      = $clog2(DEPTH)
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  we,
   input  logic [IDXW-1:0]       waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDXW-1:0]       raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Reset wins over a write in the same cycle, so an aborted transfer can never land.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_ram_completer.sv
// APB3 completer in front of a word-addressed RAM with programmable wait
// states, a write-protected upper region and error responses for misaligned,
// out-of-range and protected accesses. All bus outputs are registered.
module apb_ram_completer
   import apb_ram_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0,
   parameter int RO_BASE     = DEPTH
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int OFFW = byte_offset_width(DATA_WIDTH);
   localparam int IDXW = $clog2(DEPTH);
   // Out-of-range settings are clamped so the counter width always suffices.
   localparam int WS   = (WAIT_STATES < WAIT_STATES_MIN) ? WAIT_STATES_MIN :
                         (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;

   localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RO_A      = ADDR_WIDTH'(RO_BASE);
   localparam logic [CNT_WIDTH-1:0]  WS_CNT    = CNT_WIDTH'(WS);

   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [ADDR_WIDTH-1:0]  idx_full;
   logic [IDXW-1:0]        idx;
   logic                   misaligned;
   logic                   out_of_range;
   logic                   protected_wr;
   logic                   err;
   logic                   rd_ok;
   logic                   we;
   logic [DATA_WIDTH-1:0]  rdata;
   logic [DATA_WIDTH-1:0]  resp_data;

   // Decode the word index and error conditions from the live bus; the whole
   // upper address is compared so addresses beyond DEPTH never alias.
   always_comb begin
      idx_full     = PADDR >> OFFW;
      idx          = idx_full[IDXW-1:0];
      misaligned   = |(PADDR & BYTE_MASK);
      out_of_range = idx_full >= DEPTH_A;
      protected_wr = PWRITE && (idx_full >= RO_A);
      err          = misaligned || out_of_range || protected_wr;
      rd_ok        = !PWRITE && !err;
      resp_data    = rd_ok ? rdata : '0;
      we           = (state == RESP) && PSEL && PENABLE && PWRITE && !err;
   end

   apb_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .we      (we),
      .waddr   (idx),
      .wdata   (PWDATA),
      .raddr   (idx),
      .rdata   (rdata)
   );

   // Transfer sequencer: counts wait states, loads the response one cycle
   // before PREADY is seen, and drops PREADY after the single completing cycle.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt     <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  cnt <= WS_CNT;
                  if (WS == 0) begin
                     state   <= RESP;
                     PREADY  <= 1'b1;
                     PSLVERR <= err;
                     PRDATA  <= resp_data;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!PSEL) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_WIDTH'(1)) begin
                     state   <= RESP;
                     PREADY  <= 1'b1;
                     PSLVERR <= err;
                     PRDATA  <= resp_data;
                  end
               end
            end
            RESP: begin
               state   <= IDLE;
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
            end
         endcase
      end
   end

endmodule
